// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write-port bundle for imem_loader.
// master = stream source / imem observer, slave = the loader itself.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles a length-prefixed big-endian byte stream into 16-bit imem writes.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  imem_loader_if.slave bus,
  output logic [15:0] words_loaded,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_rst_n
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, DONE, ERR} state_t;
  localparam state_t TAIL = CSUM;
  logic [7:0] csum;
`else
  typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA_HI, DATA_LO, DONE, ERR} state_t;
  localparam state_t TAIL = DONE;
`endif

  state_t      state;
  state_t      nxt;
  logic [7:0]  len_hi;
  logic [15:0] n_words;
  logic [7:0]  data_hi;
  logic        xfer;
  logic [15:0] len_full;
  logic [15:0] wl_inc;

  assign xfer     = bus.in_valid && bus.in_ready;
  assign len_full = {len_hi, bus.in_data};
  assign wl_inc   = words_loaded + 16'd1;

  always_comb begin
    nxt = state;
    unique case (state)
      LEN_HI:  if (xfer) nxt = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          if (len_full == 16'd0)                 nxt = TAIL;
          else if (32'(len_full) > DEPTH_WORDS)  nxt = ERR;
          else                                   nxt = DATA_HI;
        end
      end
      DATA_HI: if (xfer) nxt = DATA_LO;
      DATA_LO: if (xfer) nxt = (wl_inc == n_words) ? TAIL : DATA_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM:    if (xfer) nxt = (bus.in_data == csum) ? DONE : ERR;
`endif
      DONE:    if (start) nxt = LEN_HI;
      ERR:     if (start) nxt = LEN_HI;
      default: nxt = LEN_HI;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= LEN_HI;
      len_hi         <= '0;
      n_words        <= '0;
      data_hi        <= '0;
      words_loaded   <= '0;
      bus.in_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      cpu_rst_n      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum           <= '0;
`endif
    end else begin
      state        <= nxt;
      bus.in_ready <= (nxt != DONE) && (nxt != ERR);
      busy         <= (nxt != DONE) && (nxt != ERR);
      done         <= (nxt == DONE);
      error        <= (nxt == ERR);
      cpu_rst_n    <= (nxt == DONE);
      bus.imem_we  <= 1'b0;

      unique case (state)
        LEN_HI:  if (xfer) len_hi <= bus.in_data;
        LEN_LO: begin
          if (xfer) begin
            n_words      <= len_full;
            words_loaded <= '0;
          end
        end
        DATA_HI: if (xfer) data_hi <= bus.in_data;
        DATA_LO: begin
          if (xfer) begin
            bus.imem_we    <= 1'b1;
            bus.imem_wdata <= {data_hi, bus.in_data};
            bus.imem_addr  <= ADDR_W'({words_loaded, 1'b0});
            words_loaded   <= wl_inc;
          end
        end
        DONE, ERR: if (start) words_loaded <= '0;
        default: ;
      endcase

`ifdef IMEM_LOADER_CHECKSUM_EN
      if ((state == DONE || state == ERR) && start)
        csum <= '0;
      else if (xfer && state != CSUM)
        csum <= csum ^ bus.in_data;
`endif
    end
  end

  a_addr_even: assert property (@(posedge clk) disable iff (!rst_n) !bus.imem_addr[0]);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stream-level reference model feeds an expected-write
// queue, an independent monitor pops and compares every imem write.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] words_loaded;
  logic        busy, done, error, cpu_rst_n;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(16)) bus ();

  imem_loader #(.DEPTH_WORDS(2048), .ADDR_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (bus),
    .words_loaded (words_loaded),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .cpu_rst_n    (cpu_rst_n)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;
  typedef logic [7:0] bq_t[$];

  wr_t exp_q[$];
  wr_t mon_e;
  int  total = 0;
  int  bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", 32'(bus.imem_addr), 32'(mon_e.addr));
        chk("write_data", 32'(bus.imem_wdata), 32'(mon_e.data));
      end
    end
  end

  // gmode: 0 = back-to-back, 1 = one idle cycle before every byte, 2 = random gaps
  task automatic send_byte(input logic [7:0] b, input int gmode, input bit is_lo);
    int gaps;
    int k;
    @(negedge clk);
    gaps = (gmode == 1) ? 1 : (gmode == 2) ? int'($urandom_range(0, 2)) : 0;
    for (int g = 0; g < gaps; g++) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      if (busy === 1'b1 && $urandom_range(0, 3) == 0) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    k = 0;
    while (bus.in_ready !== 1'b1 && k < 8) begin
      @(negedge clk);
      k++;
    end
    if (k == 8) chk("ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    chk("we_latency", 32'(bus.imem_we), 32'(is_lo));
  endtask

  task automatic do_start();
    @(negedge clk);
    start        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    @(posedge clk);
    #1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    chk("start_done", 32'(done), 32'd0);
    chk("start_error", 32'(error), 32'd0);
    chk("start_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("start_words", 32'(words_loaded), 32'd0);
    chk("start_in_ready", 32'(bus.in_ready), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  function automatic bq_t make_stream(input int n, input bit bad_cs);
    bq_t  s;
    logic [7:0] x;
    s.push_back(8'(n >> 8));
    s.push_back(8'(n));
    if (n > 2048) return s;
    for (int i = 0; i < 2 * n; i++) s.push_back(8'($urandom));
    x = '0;
    foreach (s[i]) x ^= s[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
    s.push_back(bad_cs ? (x ^ 8'($urandom_range(1, 255))) : x);
`else
    if (bad_cs && x == 8'h5A) s.push_back(x);
`endif
    return s;
  endfunction

  task automatic run_load(input bq_t s, input int gmode);
    int n, nb, exp_words;
    bit exp_err, over;
    logic [7:0] x;
    n = 32'({s[0], s[1]});
    over = (n > 2048);
    if (over) begin
      nb = 2; exp_err = 1'b1; exp_words = 0;
    end else begin
      nb = 2 + 2 * n; exp_err = 1'b0; exp_words = n;
      for (int i = 0; i < n; i++)
        exp_q.push_back('{addr: 16'(2 * i), data: {s[2 + 2*i], s[3 + 2*i]}});
`ifdef IMEM_LOADER_CHECKSUM_EN
      x = '0;
      for (int i = 0; i < nb; i++) x ^= s[i];
      exp_err = (s[nb] != x);
      nb++;
`endif
    end
    for (int i = 0; i < nb; i++)
      send_byte(s[i], gmode, !over && i >= 2 && i < 2 + 2*n && (i % 2 == 1));
    chk("end_done", 32'(done), 32'(!exp_err));
    chk("end_error", 32'(error), 32'(exp_err));
    chk("end_cpu_rst_n", 32'(cpu_rst_n), 32'(!exp_err));
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_in_ready", 32'(bus.in_ready), 32'd0);
    chk("end_words", 32'(words_loaded), 32'(exp_words));
    repeat (2) @(negedge clk);
    chk("writes_drained", 32'(exp_q.size()), 32'd0);
    chk("hold_done", 32'(done), 32'(!exp_err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t s;
    int  n;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("rst_imem_we", 32'(bus.imem_we), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_wdata", 32'(bus.imem_wdata), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("boot_in_ready", 32'(bus.in_ready), 32'd1);
    chk("boot_busy", 32'(busy), 32'd1);

    s = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h07};
`ifdef IMEM_LOADER_CHECKSUM_EN
    s.push_back(8'h00 ^ 8'h03 ^ 8'h12 ^ 8'h34 ^ 8'hAB ^ 8'hCD ^ 8'h00 ^ 8'h07);
`endif
    run_load(s, 0);
    do_start();
    run_load(s, 1);

    do_start();
    s = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    s.push_back(8'h00);
`endif
    run_load(s, 0);

    do_start();
    s = '{8'h08, 8'h01};
    run_load(s, 0);
    do_start();
    s = '{8'h00, 8'h01, 8'hBE, 8'hEF};
`ifdef IMEM_LOADER_CHECKSUM_EN
    s.push_back(8'h00 ^ 8'h01 ^ 8'hBE ^ 8'hEF);
`endif
    run_load(s, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_start();
    s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
    run_load(s, 0);
    do_start();
    s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
    run_load(s, 0);
`endif

    do_start();
    run_load(make_stream(2048, 1'b0), 0);

    // Reset in the middle of a 3-word load, after the first word has been written.
    do_start();
    exp_q.push_back('{addr: 16'h0000, data: 16'h1234});
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h03, 0, 1'b0);
    send_byte(8'h12, 0, 1'b0);
    send_byte(8'h34, 0, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_imem_we", 32'(bus.imem_we), 32'd0);
    chk("midrst_addr", 32'(bus.imem_addr), 32'd0);
    chk("midrst_wdata", 32'(bus.imem_wdata), 32'd0);
    chk("midrst_words", 32'(words_loaded), 32'd0);
    chk("midrst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("midrst_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rerun_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rerun_words", 32'(words_loaded), 32'd0);
    run_load(make_stream(2, 1'b0), 2);

    for (int r = 0; r < 12; r++) begin
      do_start();
      n = ($urandom_range(0, 6) == 0) ? int'($urandom_range(2049, 65535))
                                       : int'($urandom_range(0, 12));
      run_load(make_stream(n, $urandom_range(0, 3) == 0), 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
